// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared states and constants for the SPI transaction controller
package spi_pkg;

    localparam int BYTE_W      = 8;
    localparam int DEFAULT_DIV = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STORE,
        ST_DONE,
        ST_CLEAR
    } spi_state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SPI mode 0 clock with one-cycle rise/fall strobes
// The strobes mark the clk edge on which sclk itself changes level.
module spi_sclk_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = en && (cnt == CW'(DIV - 1));
    assign rise = tick && !sclk;
    assign fall = tick && sclk;

    // Disabling parks sclk low so every byte starts from the idle level.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_transaction_ctrl.sv
// rtl/spi_transaction_ctrl.sv - multi-byte SPI master driven by a control register
// Each byte takes one LOAD, 16*DIV SHIFT and one STORE cycle.
module spi_transaction_ctrl
    import spi_pkg::*;
#(
    parameter int N   = 5,
    parameter int DIV = DEFAULT_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic              cs_ctrl,
    input  logic              all_1s,
    input  logic              all_0s,
    input  logic [N:0]        n_tx_end,
    input  logic [BYTE_W-1:0] tx_data,
    output logic [N:0]        tx_addr,
    output logic [BYTE_W-1:0] rx_data,
    output logic [N:0]        rx_addr,
    output logic              rx_we,
    output logic              clr_send,
    output logic              hold_ctrl,
    output logic [N+1:0]      n_rx_end,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    spi_state_t        state_q, state_d;
    logic [N:0]        byte_cnt;
    logic [2:0]        bit_cnt;
    logic [N:0]        n_tx_end_q;
    logic              all_1s_q, all_0s_q;
    logic [BYTE_W-1:0] tx_sr, rx_sr;
    logic              sclk_rise, sclk_fall;
    logic              last_fall;

    spi_sclk_gen #(.DIV(DIV)) u_sclk (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_SHIFT),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    assign last_fall = sclk_fall && (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rx_we     = 1'b0;
        hold_ctrl = 1'b0;
        clr_send  = 1'b0;
        case (state_q)
            ST_IDLE:  if (send) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (last_fall) state_d = ST_STORE;
            ST_STORE: begin
                rx_we     = 1'b1;
                hold_ctrl = 1'b1;
                state_d   = (byte_cnt == n_tx_end_q) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                clr_send = 1'b1;
                state_d  = ST_CLEAR;
            end
            ST_CLEAR: if (!send) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            n_rx_end   <= '0;
            n_tx_end_q <= '0;
            all_1s_q   <= 1'b0;
            all_0s_q   <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    byte_cnt <= '0;
                    n_rx_end <= '0;
                    if (send) begin
                        n_tx_end_q <= n_tx_end;
                        all_1s_q   <= all_1s;
                        all_0s_q   <= all_0s;
                    end
                end
                ST_LOAD: begin
                    bit_cnt <= '0;
                    tx_sr   <= all_1s_q ? 8'hFF : (all_0s_q ? 8'h00 : tx_data);
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_sr <= {rx_sr[BYTE_W-2:0], miso};
                    end
                    if (sclk_fall) begin
                        tx_sr   <= {tx_sr[BYTE_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    // Count is published so it is valid during the STORE cycle.
                    if (last_fall) begin
                        n_rx_end <= {1'b0, byte_cnt} + (N+2)'(1);
                    end
                end
                ST_STORE: begin
                    if (byte_cnt != n_tx_end_q) begin
                        byte_cnt <= byte_cnt + (N+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_addr = byte_cnt;
    assign rx_addr = byte_cnt;
    assign rx_data = rx_sr;
    assign mosi    = (state_q == ST_SHIFT) && tx_sr[BYTE_W-1];
    assign cs_n    = !((state_q == ST_LOAD) || (state_q == ST_SHIFT) ||
                       (state_q == ST_STORE) || cs_ctrl);

endmodule

// File: tb/tb_spi_transaction_ctrl.sv
// tb/tb_spi_transaction_ctrl.sv - directed scoreboard bench for spi_transaction_ctrl
module tb_spi_transaction_ctrl;

    localparam int N  = 5;
    localparam int AW = N + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, send, cs_ctrl, all_1s, all_0s, miso, miso_tie;
    logic [AW-1:0] n_tx_end, tx_addr, rx_addr;
    logic [7:0]    tx_data, rx_data;
    logic          rx_we, clr_send, hold_ctrl, sclk, mosi, cs_n;
    logic [AW:0]   n_rx_end;

    logic          send1;
    logic [AW-1:0] n_tx_end1, tx_addr1, rx_addr1;
    logic [7:0]    tx_data1, rx_data1;
    logic          rx_we1, clr_send1, hold_ctrl1, sclk1, mosi1, cs1_n;
    logic [AW:0]   n_rx_end1;

    logic [7:0] mem [0:63];

    assign tx_data  = mem[tx_addr];
    assign tx_data1 = mem[tx_addr1];
    assign miso     = miso_tie ? 1'b1 : mosi;

    spi_transaction_ctrl #(.N(N), .DIV(2)) u_dut (
        .clk(clk), .rst(rst), .send(send), .cs_ctrl(cs_ctrl),
        .all_1s(all_1s), .all_0s(all_0s), .n_tx_end(n_tx_end),
        .tx_data(tx_data), .tx_addr(tx_addr), .rx_data(rx_data),
        .rx_addr(rx_addr), .rx_we(rx_we), .clr_send(clr_send),
        .hold_ctrl(hold_ctrl), .n_rx_end(n_rx_end), .sclk(sclk),
        .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    spi_transaction_ctrl #(.N(N), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .send(send1), .cs_ctrl(1'b0),
        .all_1s(1'b0), .all_0s(1'b0), .n_tx_end(n_tx_end1),
        .tx_data(tx_data1), .tx_addr(tx_addr1), .rx_data(rx_data1),
        .rx_addr(rx_addr1), .rx_we(rx_we1), .clr_send(clr_send1),
        .hold_ctrl(hold_ctrl1), .n_rx_end(n_rx_end1), .sclk(sclk1),
        .mosi(mosi1), .miso(mosi1), .cs_n(cs1_n)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    rx;
        logic [7:0]    tx;
        logic [AW:0]   nrx;
        logic          hold;
        int            nbits;
        int            cyc;
    } ev_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    rx;
        logic [7:0]    tx;
        logic [AW:0]   nrx;
    } exp_t;

    ev_t  obs[$];
    exp_t exp_q[$];

    int         cyc = 0, nbits = 0, clr_cnt = 0, clr_cyc = 0;
    logic [7:0] bits = 8'h00;
    logic       sclk_d = 1'b0;

    // Observed side: mosi bits captured at each sclk rise, one event per rx_we.
    always @(negedge clk) begin
        cyc    <= cyc + 1;
        sclk_d <= sclk;
        if (rst) begin
            nbits <= 0;
            bits  <= 8'h00;
        end else begin
            if (sclk && !sclk_d) begin
                bits  <= {bits[6:0], mosi};
                nbits <= nbits + 1;
            end
            if (rx_we) begin
                obs.push_back(ev_t'{rx_addr, rx_data, bits, n_rx_end, hold_ctrl, nbits, cyc});
                nbits <= 0;
            end
            if (clr_send) begin
                clr_cnt <= clr_cnt + 1;
                clr_cyc <= cyc;
            end
        end
    end

    int checks = 0, errors = 0, rd = 0;
    int lat, glitch, cnt_a, cnt_b, cnt_c, clr_base, seen, rises;
    logic prev, hit, low, done1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input int a, input logic [7:0] r, input logic [7:0] t);
        exp_q.push_back(exp_t'{AW'(a), r, t, (AW+1)'(a + 1)});
    endtask

    task automatic score(input int nb);
        exp_t e;
        repeat (2) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            e = exp_q.pop_front();
            if (rd < obs.size()) begin
                chk("rx_addr",   obs[rd].addr,  e.addr);
                chk("rx_data",   obs[rd].rx,    e.rx);
                chk("mosi_byte", obs[rd].tx,    e.tx);
                chk("mosi_bits", obs[rd].nbits, 8);
                chk("n_rx_end",  obs[rd].nrx,   e.nrx);
                chk("hold_ctrl", obs[rd].hold,  1);
                rd++;
            end else begin
                chk("rx_we_missing", obs.size(), rd + 1);
            end
        end
    endtask

    task automatic run_txn(input int nb, output int lat_o, output int glitch_o);
        int  k = 0;
        int  n = 0;
        bit  lo = 0;
        bit  done = 0;
        lat_o    = -1;
        glitch_o = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            if (!cs_n) lo = 1;
            if (lo) k++;
            if (lo && n < nb && cs_n) glitch_o++;
            if (rx_we) begin
                n++;
                if (lat_o < 0) lat_o = k;
            end
            if (clr_send) done = 1;
        end
        chk("txn_completes", done, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sclk"},      sclk,      0);
        chk({tag, "_mosi"},      mosi,      0);
        chk({tag, "_cs_n"},      cs_n,      1);
        chk({tag, "_rx_we"},     rx_we,     0);
        chk({tag, "_clr_send"},  clr_send,  0);
        chk({tag, "_hold_ctrl"}, hold_ctrl, 0);
        chk({tag, "_tx_addr"},   tx_addr,   0);
        chk({tag, "_rx_addr"},   rx_addr,   0);
        chk({tag, "_rx_data"},   rx_data,   0);
        chk({tag, "_n_rx_end"},  n_rx_end,  0);
    endtask

    initial begin
        rst = 1'b1; send = 1'b1; cs_ctrl = 1'b0; all_1s = 1'b0; all_0s = 1'b0;
        miso_tie = 1'b0; n_tx_end = '0; send1 = 1'b0; n_tx_end1 = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        // Single byte loopback with send already pending through reset.
        push_exp(0, 8'hA5, 8'hA5);
        rst = 1'b0;
        run_txn(1, lat, glitch);
        send = 1'b0;
        chk("latency_div2", lat, 34);
        score(1);
        chk("clr_send_count", clr_cnt, 1);
        chk("clr_after_store", clr_cyc - obs[0].cyc, 1);

        // Four bytes, miso tied high; mid-transaction config changes must be ignored.
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        miso_tie = 1'b1; n_tx_end = 6'd3;
        for (int i = 0; i < 4; i++) push_exp(i, 8'hFF, mem[i]);
        repeat (2) @(negedge clk);
        send = 1'b1;
        repeat (2) @(negedge clk);
        n_tx_end = 6'd0; all_1s = 1'b1;
        run_txn(4, lat, glitch);
        send = 1'b0; all_1s = 1'b0; miso_tie = 1'b0;
        chk("cs_low_throughout", glitch, 0);
        score(4);

        // Pattern overrides: both set gives ones, all_0s alone gives zeros.
        mem[0] = 8'h3C; all_1s = 1'b1; all_0s = 1'b1;
        push_exp(0, 8'hFF, 8'hFF);
        repeat (2) @(negedge clk);
        send = 1'b1;
        run_txn(1, lat, glitch);
        send = 1'b0;
        score(1);
        all_1s = 1'b0;
        push_exp(0, 8'h00, 8'h00);
        send = 1'b1;
        run_txn(1, lat, glitch);
        send = 1'b0; all_0s = 1'b0;
        score(1);

        // Reset during bit 4 of byte 2.
        mem[0] = 8'h11; n_tx_end = 6'd3;
        push_exp(0, 8'h11, 8'h11);
        push_exp(1, 8'h22, 8'h22);
        clr_base = clr_cnt;
        send = 1'b1;
        seen = 0; rises = 0; prev = 1'b0; hit = 1'b0;
        for (int t = 0; t < 3000 && !hit; t++) begin
            @(negedge clk);
            if (rx_we) seen++;
            if (seen == 2 && sclk && !prev) rises++;
            prev = sclk;
            if (rises == 4) hit = 1'b1;
        end
        chk("reached_byte2_bit4", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        rst = 1'b0; send = 1'b0;
        score(2);
        cnt_a = 0;
        repeat (60) begin
            @(negedge clk);
            if (rx_we) cnt_a++;
        end
        chk("no_rx_we_after_reset", cnt_a, 0);
        chk("no_clr_after_reset", clr_cnt, clr_base);

        // send held high after clr_send: stays in CLEAR until send drops.
        n_tx_end = 6'd0; mem[0] = 8'h5A;
        push_exp(0, 8'h5A, 8'h5A);
        send = 1'b1;
        run_txn(1, lat, glitch);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        repeat (80) begin
            @(negedge clk);
            if (rx_we) cnt_a++;
            if (clr_send) cnt_b++;
            if (!cs_n) cnt_c++;
        end
        chk("clear_hold_rx_we", cnt_a, 0);
        chk("clear_hold_clr_send", cnt_b, 0);
        chk("clear_hold_cs_n", cnt_c, 0);
        score(1);
        send = 1'b0;
        repeat (3) @(negedge clk);
        mem[0] = 8'h96;
        push_exp(0, 8'h96, 8'h96);
        send = 1'b1;
        run_txn(1, lat, glitch);
        send = 1'b0;
        score(1);
        cnt_a = 0;
        repeat (40) begin
            @(negedge clk);
            if (rx_we) cnt_a++;
        end
        chk("single_retrigger", cnt_a, 0);

        // Manual chip-select hold while idle.
        cs_ctrl = 1'b1;
        @(negedge clk);
        chk("cs_ctrl_cs_n", cs_n, 0);
        cnt_a = 0; cnt_b = 0;
        repeat (10) begin
            @(negedge clk);
            if (rx_we) cnt_a++;
            if (sclk) cnt_b++;
        end
        chk("cs_ctrl_no_rx_we", cnt_a, 0);
        chk("cs_ctrl_sclk_low", cnt_b, 0);
        cs_ctrl = 1'b0;
        @(negedge clk);
        chk("cs_ctrl_release", cs_n, 1);

        // DIV=1 instance: LOAD through STORE in 18 cycles.
        mem[0] = 8'hC3;
        send1 = 1'b1;
        low = 1'b0; done1 = 1'b0; lat = -1; cnt_a = 0; cnt_b = 0;
        for (int t = 0; t < 500 && !done1; t++) begin
            @(negedge clk);
            if (!cs1_n) low = 1'b1;
            if (low) cnt_a++;
            if (rx_we1 && lat < 0) begin
                lat   = cnt_a;
                cnt_b = int'(rx_data1);
            end
            if (clr_send1) done1 = 1'b1;
        end
        send1 = 1'b0;
        chk("div1_done", done1, 1);
        chk("latency_div1", lat, 18);
        chk("div1_rx_data", cnt_b, 32'hC3);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
